// File: rtl/button_conditioner.sv
// Front end for four active-low buttons: sync, debounce, rising-edge pulses, and a long-press test pulse.
// Define AUTOREPEAT_EN to make feeding/healing repeat while their button stays held.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLD_CYCLES     = 250000000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_feed_n,
   input  logic       btn_heal_n,
   input  logic       btn_next_n,
   input  logic       btn_test_n,
   output logic       feeding,
   output logic       healing,
   output logic       change_state,
   output logic       test,
   output logic [3:0] btn_level,
   output logic [1:0] testState
);

   localparam int DebW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HoldW = $clog2(HOLD_CYCLES + 1);
   localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : gBadParam
      $error("button_conditioner: cycle parameters must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FIRED = 2'd2
   } testState_t;

   logic [3:0]       rawN;
   logic [3:0]       syncA;
   logic [3:0]       syncB;
   logic [3:0]       pressed;
   logic [DebW-1:0]  debCnt [4];
   logic [3:0]       levelQ;
   logic [3:0]       rise;
   logic [1:0]       repFire;
   logic             feedEvt;
   logic             healEvt;
   testState_t       state;
   testState_t       stateNext;
   logic [HoldW-1:0] holdCnt;
   logic [HoldW-1:0] holdCntNext;

   assign rawN    = {btn_test_n, btn_next_n, btn_heal_n, btn_feed_n};
   assign pressed = ~syncB;

   // Sync flops reset to the released level so a held button re-debounces after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         syncA <= '1;
         syncB <= '1;
      end else begin
         syncA <= rawN;
         syncB <= syncA;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) debCnt[i] <= '0;
         btn_level <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (pressed[i] == btn_level[i]) begin
               debCnt[i] <= '0;
            end else if (debCnt[i] == DebLast) begin
               debCnt[i]    <= '0;
               btn_level[i] <= ~btn_level[i];
            end else begin
               debCnt[i] <= debCnt[i] + DebW'(1);
            end
         end
      end
   end

   assign rise = btn_level & ~levelQ;

`ifdef AUTOREPEAT_EN
   localparam int RepW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

   logic [RepW-1:0] repCnt [2];

   // Period counter restarts at the initial pulse, so repeats land every REPEAT_CYCLES after it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) repCnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!btn_level[i] || rise[i] || repCnt[i] == RepLast) repCnt[i] <= '0;
            else repCnt[i] <= repCnt[i] + RepW'(1);
         end
      end
   end

   always_comb begin
      repFire = '0;
      for (int i = 0; i < 2; i++) repFire[i] = btn_level[i] && !rise[i] && (repCnt[i] == RepLast);
   end
`else
   assign repFire = '0;
`endif

   assign feedEvt = rise[0] | repFire[0];
   assign healEvt = rise[1] | repFire[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         levelQ       <= '0;
         feeding      <= 1'b0;
         healing      <= 1'b0;
         change_state <= 1'b0;
      end else begin
         levelQ       <= btn_level;
         feeding      <= feedEvt;
         healing      <= healEvt & ~feedEvt;
         change_state <= rise[2];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         holdCnt <= '0;
      end else begin
         state   <= stateNext;
         holdCnt <= holdCntNext;
      end
   end

   // test is decoded from registered state, so it is high for the single cycle the hold completes.
   always_comb begin
      stateNext   = state;
      holdCntNext = holdCnt;
      test        = 1'b0;
      case (state)
         IDLE: begin
            if (btn_level[3]) begin
               stateNext   = HOLD;
               holdCntNext = '0;
            end
         end
         HOLD: begin
            if (!btn_level[3]) begin
               stateNext = IDLE;
            end else if (holdCnt == HoldLast) begin
               test      = 1'b1;
               stateNext = FIRED;
            end else begin
               holdCntNext = holdCnt + HoldW'(1);
            end
         end
         FIRED: begin
            if (!btn_level[3]) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign testState = state;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short cycle parameters; pulses are scored against a
// time-stamped expected queue, levels and FSM state are checked at fixed cycles.
module tb_button_conditioner;

   localparam int DEB  = 4;
   localparam int HOLD = 20;
   localparam int REP  = 8;
   localparam int W    = 36;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btnFeedN = 1'b1;
   logic       btnHealN = 1'b1;
   logic       btnNextN = 1'b1;
   logic       btnTestN = 1'b1;
   logic       feeding;
   logic       healing;
   logic       changeState;
   logic       test;
   logic [3:0] btnLevel;
   logic [1:0] testState;

   int         cyc = 0;
   int         nTests = 0;
   int         nFail = 0;
   int         t0 = 0;
   bit         monEn = 1'b0;
   logic [W-1:0] exp_q[$];

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (REP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_feed_n  (btnFeedN),
      .btn_heal_n  (btnHealN),
      .btn_next_n  (btnNextN),
      .btn_test_n  (btnTestN),
      .feeding     (feeding),
      .healing     (healing),
      .change_state(changeState),
      .test        (test),
      .btn_level   (btnLevel),
      .testState   (testState)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic waitEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic runTo(input int n);
      while (cyc < n) waitEdge();
   endtask

   task automatic pushPulse(input int c, input logic [3:0] v);
      exp_q.push_back({32'(c), v});
   endtask

   task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nTests++;
      assert (got === exp) else begin
         nFail++;
         $error("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Any pulse output high is matched, in time order, against the expected queue.
   logic [W-1:0] monGot;
   logic [W-1:0] monExp;
   always @(negedge clk) begin
      if (monEn && {test, changeState, healing, feeding} !== 4'b0000) begin
         monGot = {32'(cyc), test, changeState, healing, feeding};
         if (exp_q.size() == 0) monExp = '0;
         else monExp = exp_q.pop_front();
         nTests++;
         assert (monGot === monExp) else begin
            nFail++;
            $error("FAIL pulse got=%h exp=%h (cycle,{test,next,heal,feed})", monGot, monExp);
         end
      end
   end

   initial begin
      // Reset
      repeat (3) waitEdge();
      checkVal("reset_pulses", 8'({test, changeState, healing, feeding}), 8'h00);
      checkVal("reset_level", 8'(btnLevel), 8'h00);
      checkVal("reset_state", 8'(testState), 8'h00);
      rst = 1'b1;
      monEn = 1'b1;
      repeat (5) waitEdge();

      // Feed press held 40 cycles
      waitEdge();
      t0 = cyc;
      btnFeedN = 1'b0;
      pushPulse(t0 + 7, 4'b0001);
`ifdef AUTOREPEAT_EN
      pushPulse(t0 + 15, 4'b0001);
      pushPulse(t0 + 23, 4'b0001);
      pushPulse(t0 + 31, 4'b0001);
      pushPulse(t0 + 39, 4'b0001);
`endif
      runTo(t0 + 5);
      checkVal("feed_level_before", 8'(btnLevel), 8'h00);
      runTo(t0 + 6);
      checkVal("feed_level_rise", 8'(btnLevel), 8'h01);
      runTo(t0 + 40);
      btnFeedN = 1'b1;
      runTo(t0 + 45);
      checkVal("feed_level_held", 8'(btnLevel), 8'h01);
      runTo(t0 + 46);
      checkVal("feed_level_fall", 8'(btnLevel), 8'h00);
      runTo(t0 + 55);

      // Heal bouncing: 3 low / 1 high, five times
      for (int k = 0; k < 5; k++) begin
         btnHealN = 1'b0;
         repeat (3) begin
            waitEdge();
            checkVal("bounce_level", 8'(btnLevel), 8'h00);
         end
         btnHealN = 1'b1;
         waitEdge();
         checkVal("bounce_level", 8'(btnLevel), 8'h00);
      end
      repeat (8) waitEdge();
      checkVal("bounce_level_end", 8'(btnLevel), 8'h00);

      // Test long press, 40 cycles
      waitEdge();
      t0 = cyc;
      btnTestN = 1'b0;
      pushPulse(t0 + 26, 4'b1000);
      runTo(t0 + 6);
      checkVal("test_level_rise", 8'(btnLevel), 8'h08);
      runTo(t0 + 8);
      checkVal("test_state_hold", 8'(testState), 8'h01);
      runTo(t0 + 27);
      checkVal("test_state_fired", 8'(testState), 8'h02);
      runTo(t0 + 40);
      btnTestN = 1'b1;
      runTo(t0 + 47);
      checkVal("test_state_idle", 8'(testState), 8'h00);
      runTo(t0 + 55);

      // Test short press, 15 cycles: no pulse
      waitEdge();
      t0 = cyc;
      btnTestN = 1'b0;
      runTo(t0 + 15);
      btnTestN = 1'b1;
      runTo(t0 + 21);
      checkVal("short_state_hold", 8'(testState), 8'h01);
      runTo(t0 + 22);
      checkVal("short_state_idle", 8'(testState), 8'h00);
      runTo(t0 + 40);

      // Feed and heal together: feed wins
      waitEdge();
      t0 = cyc;
      btnFeedN = 1'b0;
      btnHealN = 1'b0;
      pushPulse(t0 + 7, 4'b0001);
      runTo(t0 + 6);
      checkVal("both_level", 8'(btnLevel), 8'h03);
      runTo(t0 + 8);
      btnFeedN = 1'b1;
      btnHealN = 1'b1;
      runTo(t0 + 30);

      // Heal alone
      waitEdge();
      t0 = cyc;
      btnHealN = 1'b0;
      pushPulse(t0 + 7, 4'b0010);
      runTo(t0 + 8);
      btnHealN = 1'b1;
      runTo(t0 + 30);

      // Next, held long enough that a repeat would show
      waitEdge();
      t0 = cyc;
      btnNextN = 1'b0;
      pushPulse(t0 + 7, 4'b0100);
      runTo(t0 + 6);
      checkVal("next_level", 8'(btnLevel), 8'h04);
      runTo(t0 + 20);
      btnNextN = 1'b1;
      runTo(t0 + 40);

      // Reset while feed and test are held
      waitEdge();
      t0 = cyc;
      btnFeedN = 1'b0;
      btnTestN = 1'b0;
      pushPulse(t0 + 7, 4'b0001);
`ifdef AUTOREPEAT_EN
      pushPulse(t0 + 15, 4'b0001);
`endif
      runTo(t0 + 15);
      checkVal("pre_reset_state", 8'(testState), 8'h01);
      rst = 1'b0;
      runTo(t0 + 16);
      checkVal("midrst_pulses", 8'({test, changeState, healing, feeding}), 8'h00);
      checkVal("midrst_level", 8'(btnLevel), 8'h00);
      checkVal("midrst_state", 8'(testState), 8'h00);
      rst = 1'b1;
      pushPulse(t0 + 23, 4'b0001);
`ifdef AUTOREPEAT_EN
      pushPulse(t0 + 31, 4'b0001);
      pushPulse(t0 + 39, 4'b0001);
`endif
      pushPulse(t0 + 42, 4'b1000);
`ifdef AUTOREPEAT_EN
      pushPulse(t0 + 47, 4'b0001);
`endif
      runTo(t0 + 21);
      checkVal("post_rst_level_before", 8'(btnLevel), 8'h00);
      runTo(t0 + 22);
      checkVal("post_rst_level", 8'(btnLevel), 8'h09);
      runTo(t0 + 48);
      btnFeedN = 1'b1;
      btnTestN = 1'b1;
      runTo(t0 + 70);
      checkVal("final_level", 8'(btnLevel), 8'h00);

      nTests++;
      assert (exp_q.size() == 0) else begin
         nFail++;
         $error("FAIL missing_pulses got=%0d pending exp=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
